// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the primary, secondary, reservation, query and register-file write signals of regfile_wb_arbiter.
// The master side drives results and queries; the slave side (the arbiter) drives the write port and status.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;

  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;

  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;

  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output p_valid, p_addr, p_data,
    output s_valid, s_addr, s_data,
    output rsv_valid, rsv_addr,
    output rs1_addr, rs2_addr,
    input  s_ready, rs1_busy, rs2_busy,
    input  wb_en, wb_addr, wb_data, fifo_count
  );

  modport slave (
    input  p_valid, p_addr, p_data,
    input  s_valid, s_addr, s_data,
    input  rsv_valid, rsv_addr,
    input  rs1_addr, rs2_addr,
    output s_ready, rs1_busy, rs2_busy,
    output wb_en, wb_addr, wb_data, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write arbiter: primary has fixed priority (1-cycle latency), secondary is queued (>=2 cycles,
// s_ready low when the queue is full) with a per-register busy scoreboard; WB_SECONDARY_BYPASS_EN enables 1-cycle bypass.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int NREG  = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] q_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] q_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              s_ready;
  logic              p_sel;
  logic              s_acc;
  logic              s_keep;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;

  // Readiness depends only on the registered count, so a full queue never accepts while popping.
  assign s_ready = (count_q < DEPTH_C);

  always_comb begin
    p_sel  = bus.p_valid && (bus.p_addr != '0);
    s_acc  = bus.s_valid && s_ready;
    s_keep = s_acc && (bus.s_addr != '0);
    pop    = !p_sel && (count_q != '0);
`ifdef WB_SECONDARY_BYPASS_EN
    bypass = !p_sel && (count_q == '0) && s_keep;
`else
    bypass = 1'b0;
`endif
    push   = s_keep && !bypass;
  end

  always_comb begin
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    clr_en    = 1'b0;
    clr_addr  = '0;
    if (p_sel) begin
      wb_en_d   = 1'b1;
      wb_addr_d = bus.p_addr;
      wb_data_d = bus.p_data;
    end else if (pop) begin
      wb_en_d   = 1'b1;
      wb_addr_d = q_addr_q[rd_ptr_q];
      wb_data_d = q_data_q[rd_ptr_q];
      clr_en    = 1'b1;
      clr_addr  = q_addr_q[rd_ptr_q];
    end else if (bypass) begin
      wb_en_d   = 1'b1;
      wb_addr_d = bus.s_addr;
      wb_data_d = bus.s_data;
      clr_en    = 1'b1;
      clr_addr  = bus.s_addr;
    end
  end

  always_comb begin
    q_addr_d = q_addr_q;
    q_data_d = q_data_q;
    if (push) begin
      q_addr_d[wr_ptr_q] = bus.s_addr;
      q_data_d[wr_ptr_q] = bus.s_data;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // A reservation issued in the same cycle as the completing write must survive.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (bus.rsv_valid && (bus.rsv_addr != '0)) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_addr_q  <= '{default: '0};
      q_data_q  <= '{default: '0};
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      q_addr_q  <= q_addr_d;
      q_data_q  <= q_data_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.fifo_count = count_q;
  assign bus.wb_en      = wb_en_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.rs1_busy   = (bus.rs1_addr != '0) && busy_q[bus.rs1_addr];
  assign bus.rs2_busy   = (bus.rs2_addr != '0) && busy_q[bus.rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected register-file writes, a negedge monitor checks them.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FD = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  wr_t  exp_q[$];
  wr_t  mon_w;
  int   sidx;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) bus ();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = AW'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic idle_inputs();
    bus.p_valid   = 1'b0;
    bus.p_addr    = '0;
    bus.p_data    = '0;
    bus.s_valid   = 1'b0;
    bus.s_addr    = '0;
    bus.s_data    = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_addr  = '0;
    bus.rs1_addr  = '0;
    bus.rs2_addr  = '0;
  endtask

  // Monitor: every register-file write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.wb_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, want no write", bus.wb_addr, bus.wb_data);
      end else begin
        mon_w = exp_q.pop_front();
        if (bus.wb_addr !== mon_w.addr || bus.wb_data !== mon_w.data) begin
          failures++;
          $display("FAIL wb_seq: got addr=%0d data=%h, want addr=%0d data=%h",
                   bus.wb_addr, bus.wb_data, mon_w.addr, mon_w.data);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    bus.rs1_addr = 5'd7;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
    chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Primary write, then idle: enable drops, address/data hold.
    bus.p_valid = 1'b1; bus.p_addr = 5'd5; bus.p_data = 32'hDEADBEEF;
    expect_wr(5, 32'hDEADBEEF);
    step();
    chk("prim_wb_en", 32'(bus.wb_en), 32'd1);
    chk("prim_wb_addr", 32'(bus.wb_addr), 32'd5);
    chk("prim_wb_data", bus.wb_data, 32'hDEADBEEF);
    bus.p_valid = 1'b0;
    step();
    chk("idle_wb_en", 32'(bus.wb_en), 32'd0);
    chk("idle_wb_addr_hold", 32'(bus.wb_addr), 32'd5);
    chk("idle_wb_data_hold", bus.wb_data, 32'hDEADBEEF);

    // Reserve r7, then complete it through the secondary port.
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7;
    step();
    bus.rsv_valid = 1'b0;
    #1;
    chk("rsv_busy_set", 32'(bus.rs1_busy), 32'd1);
    bus.s_valid = 1'b1; bus.s_addr = 5'd7; bus.s_data = 32'h11;
    chk("sec_s_ready", 32'(bus.s_ready), 32'd1);
    expect_wr(7, 32'h11);
    step();
    bus.s_valid = 1'b0;
    #1;
`ifdef WB_SECONDARY_BYPASS_EN
    chk("sec_bypass_wb_en", 32'(bus.wb_en), 32'd1);
    chk("sec_bypass_wb_addr", 32'(bus.wb_addr), 32'd7);
    chk("sec_bypass_busy_clr", 32'(bus.rs1_busy), 32'd0);
`else
    chk("sec_lat1_wb_en", 32'(bus.wb_en), 32'd0);
    chk("sec_lat1_busy", 32'(bus.rs1_busy), 32'd1);
    chk("sec_lat1_count", 32'(bus.fifo_count), 32'd1);
    step();
    chk("sec_lat2_wb_en", 32'(bus.wb_en), 32'd1);
    chk("sec_lat2_wb_addr", 32'(bus.wb_addr), 32'd7);
    chk("sec_lat2_busy_clr", 32'(bus.rs1_busy), 32'd0);
`endif
    step();

    // Primary busy for 6 cycles while 5 secondary results are offered.
    for (int i = 0; i < 6; i++) expect_wr(10 + i, 32'h100 + 32'(i));
    for (int j = 0; j < 5; j++) expect_wr(20 + j, 32'h200 + 32'(j));
    sidx = 0;
    for (int i = 0; i < 6; i++) begin
      bus.p_valid = 1'b1; bus.p_addr = AW'(10 + i); bus.p_data = 32'h100 + 32'(i);
      bus.s_valid = 1'b1; bus.s_addr = AW'(20 + sidx); bus.s_data = 32'h200 + 32'(sidx);
      #1;
      chk("fill_s_ready", 32'(bus.s_ready), (i < 4) ? 32'd1 : 32'd0);
      step();
      if (i < 4) sidx++;
    end
    bus.p_valid = 1'b0;
    #1;
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    chk("full_s_ready", 32'(bus.s_ready), 32'd0);
    step();
    chk("drain1_count", 32'(bus.fifo_count), 32'd3);
    chk("drain1_s_ready", 32'(bus.s_ready), 32'd1);
    step();
    bus.s_valid = 1'b0;
    chk("pushpop_count", 32'(bus.fifo_count), 32'd3);
    step(); step(); step();
    chk("drained_count", 32'(bus.fifo_count), 32'd0);
    step();
    chk("drained_wb_en", 32'(bus.wb_en), 32'd0);

    // Zero-address secondary is dropped; zero-address primary lets the queue drain.
    bus.p_valid = 1'b1; bus.p_addr = 5'd9; bus.p_data = 32'h900;
    bus.s_valid = 1'b1; bus.s_addr = 5'd12; bus.s_data = 32'hC0C;
    expect_wr(9, 32'h900);
    step();
    chk("zero_prefill_count", 32'(bus.fifo_count), 32'd1);
    bus.p_addr = 5'd8; bus.p_data = 32'h801;
    bus.s_addr = 5'd0; bus.s_data = 32'h55;
    expect_wr(8, 32'h801);
    step();
    chk("s_zero_drop_count", 32'(bus.fifo_count), 32'd1);
    bus.s_valid = 1'b0;
    bus.p_addr = 5'd0; bus.p_data = 32'hBAD;
    expect_wr(12, 32'hC0C);
    step();
    chk("p_zero_pop_wb_en", 32'(bus.wb_en), 32'd1);
    chk("p_zero_pop_wb_addr", 32'(bus.wb_addr), 32'd12);
    chk("p_zero_pop_count", 32'(bus.fifo_count), 32'd0);
    bus.p_valid = 1'b0;
    bus.s_valid = 1'b1; bus.s_addr = 5'd0; bus.s_data = 32'h66;
    step();
    bus.s_valid = 1'b0;
    chk("s_zero_no_wb", 32'(bus.wb_en), 32'd0);
    chk("s_zero_count", 32'(bus.fifo_count), 32'd0);

    // Reservation of r3 in the same cycle as the queued r3 write retires.
    bus.p_valid = 1'b1; bus.p_addr = 5'd4; bus.p_data = 32'h44;
    bus.s_valid = 1'b1; bus.s_addr = 5'd3; bus.s_data = 32'h33;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd3;
    expect_wr(4, 32'h44);
    expect_wr(3, 32'h33);
    step();
    bus.p_valid = 1'b0; bus.s_valid = 1'b0;
    bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd0;
    #1;
    chk("r3_busy_before", 32'(bus.rs1_busy), 32'd1);
    chk("r3_count", 32'(bus.fifo_count), 32'd1);
    step();
    bus.rsv_valid = 1'b0;
    chk("r3_pop_wb_addr", 32'(bus.wb_addr), 32'd3);
    chk("r3_set_wins", 32'(bus.rs1_busy), 32'd1);
    chk("rs2_zero_busy", 32'(bus.rs2_busy), 32'd0);
    bus.p_valid = 1'b1; bus.p_addr = 5'd3; bus.p_data = 32'h3A;
    expect_wr(3, 32'h3A);
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd0;
    step();
    bus.p_valid = 1'b0; bus.rsv_valid = 1'b0;
    chk("prim_no_clear", 32'(bus.rs1_busy), 32'd1);
    chk("rsv_zero_busy", 32'(bus.rs2_busy), 32'd0);

    // Fill four reserved entries, drain one, then reset asynchronously.
    for (int i = 0; i < 4; i++) begin
      bus.p_valid = 1'b1; bus.p_addr = AW'(1 + i); bus.p_data = 32'h10 + 32'(i);
      bus.s_valid = 1'b1; bus.s_addr = AW'(16 + i); bus.s_data = 32'h600 + 32'(i);
      bus.rsv_valid = 1'b1; bus.rsv_addr = AW'(16 + i);
      expect_wr(1 + i, 32'h10 + 32'(i));
      step();
    end
    bus.p_valid = 1'b0; bus.s_valid = 1'b0; bus.rsv_valid = 1'b0;
    expect_wr(16, 32'h600);
    step();
    bus.rs1_addr = 5'd17; bus.rs2_addr = 5'd16;
    #1;
    chk("mid_drain_count", 32'(bus.fifo_count), 32'd3);
    chk("mid_drain_busy17", 32'(bus.rs1_busy), 32'd1);
    chk("mid_drain_busy16_clr", 32'(bus.rs2_busy), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.rs2_addr = 5'd18;
    #1;
    chk("arst_wb_en", 32'(bus.wb_en), 32'd0);
    chk("arst_wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("arst_count", 32'(bus.fifo_count), 32'd0);
    chk("arst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("arst_busy17", 32'(bus.rs1_busy), 32'd0);
    chk("arst_busy18", 32'(bus.rs2_busy), 32'd0);
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_wb_en", 32'(bus.wb_en), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
